// File: rtl/idev_serial_rx.sv
// Serial receiver for CPU input device 0: recovers 7-bit async frames from rxd by
// mid-bit sampling and holds the last good character plus a new-data toggle flag.
module idev_serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_bar,
    input  logic       rxd,
    output logic [7:0] idev_data,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAITHI = 3'd5
    } state_t;

    localparam logic [7:0] FULL_CNT = 8'(CLKS_PER_BIT);
    localparam logic [7:0] HALF_CNT = 8'(CLKS_PER_BIT / 2);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  shift_q, shift_d;
    logic        par_bad_q, par_bad_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        ferr_q, ferr_d;
    logic        perr_q, perr_d;
    logic        rxs;
    logic        tick;

    assign rxs  = sync2_q;
    // Counter reads 1 in the cycle of the sample point.
    assign tick = (cnt_q == 8'd1);

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 3'd0;
            shift_q   <= 7'd0;
            par_bad_q <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxs && prev_q) begin
                    state_d   = S_START;
                    cnt_d     = HALF_CNT;
                    bit_d     = 3'd0;
                    par_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = FULL_CNT;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[6:1]};
                    cnt_d   = FULL_CNT;
                    if (bit_q == 3'd6) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_bad_d = ((^shift_q) ^ rxs) != PARITY_ODD;
                    cnt_d     = FULL_CNT;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d = {~data_q[7], shift_q};
                        end
                    end else begin
                        // Bad stop: wait for the line to return high so a break reports once.
                        state_d = S_WAITHI;
                        ferr_d  = 1'b1;
                        perr_d  = par_bad_q;
                    end
                end
            end
            S_WAITHI: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign idev_data  = data_q;
    assign busy       = busy_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_idev_serial_rx.sv
// Directed bench for idev_serial_rx: one instance without parity, one with even parity,
// driven from a vector table plus hand-written timing, glitch, break and reset sequences.
module tb_idev_serial_rx;

    localparam int N = 16;

    typedef struct {
        logic [6:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rxd_a, rxd_b;
    logic [7:0] idev_a, idev_b;
    logic       busy_a, busy_b, fe_a_o, fe_b_o, pe_a_o, pe_b_o;
    logic [2:0] st_a, st_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_a = 0, pe_a = 0, fe_b = 0, pe_b = 0, both_b = 0;
    int chg_a = 0, rise_a = 0, fall_a = 0;
    logic [7:0] last_a = 8'h00;
    logic       busy_last_a = 1'b0;

    always #5 clk = ~clk;

    idev_serial_rx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_a (
        .clk(clk), .rst_bar(rst_a), .rxd(rxd_a), .idev_data(idev_a), .busy(busy_a),
        .frame_err(fe_a_o), .parity_err(pe_a_o), .dbg_state(st_a)
    );

    idev_serial_rx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_b (
        .clk(clk), .rst_bar(rst_b), .rxd(rxd_b), .idev_data(idev_b), .busy(busy_b),
        .frame_err(fe_b_o), .parity_err(pe_b_o), .dbg_state(st_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: pulse counters and edge timestamps, sampled on the falling edge.
    always @(negedge clk) begin
        if (fe_a_o) fe_a++;
        if (pe_a_o) pe_a++;
        if (fe_b_o) fe_b++;
        if (pe_b_o) pe_b++;
        if (fe_b_o && pe_b_o) both_b++;
        if (idev_a != last_a) begin
            chg_a  = cyc;
            last_a = idev_a;
        end
        if (busy_a && !busy_last_a) rise_a = cyc;
        if (!busy_a && busy_last_a) fall_a = cyc;
        busy_last_a = busy_a;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rxd_a = v;
        else          rxd_b = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [6:0] d, input logic use_par,
                              input logic pbit, input logic stop, input int gap);
        set_line(sel, 1'b0);
        wait_cycles(N);
        for (int i = 0; i < 7; i++) begin
            set_line(sel, d[i]);
            wait_cycles(N);
        end
        if (use_par) begin
            set_line(sel, pbit);
            wait_cycles(N);
        end
        set_line(sel, stop);
        wait_cycles(N);
        if (gap > 0) begin
            set_line(sel, 1'b1);
            wait_cycles(gap);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int t0, fe0, pe0, be0;

        vecs[0] = '{7'h00, 1'b1, 8'h00, 0};
        vecs[1] = '{7'h7F, 1'b1, 8'hFF, 0};
        vecs[2] = '{7'h55, 1'b0, 8'hFF, 1};
        vecs[3] = '{7'h2A, 1'b1, 8'h2A, 0};
        vecs[4] = '{7'h13, 1'b1, 8'h93, 0};
        vecs[5] = '{7'h6C, 1'b0, 8'h93, 1};
        vecs[6] = '{7'h01, 1'b1, 8'h01, 0};

        rxd_a = 1'b1;
        rxd_b = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_cycles(3);
        check("reset_data_a", idev_a, 8'h00);
        check("reset_busy_a", busy_a, 0);
        check("reset_ferr_a", fe_a_o, 0);
        check("reset_perr_a", pe_a_o, 0);
        check("reset_data_b", idev_b, 8'h00);
        rst_a = 1'b1;
        rst_b = 1'b1;
        wait_cycles(5);

        // Single frame with exact latency.
        t0  = cyc;
        fe0 = fe_a;
        pe0 = pe_a;
        send_frame(0, 7'h41, 1'b0, 1'b0, 1'b1, 10);
        check("single_data", idev_a, 8'hC1);
        check("single_latency", chg_a - t0, 139);
        check("single_busy_rise", rise_a - t0, 3);
        check("single_busy_low", busy_a, 0);
        check("single_errs", (fe_a - fe0) + (pe_a - pe0), 0);

        // Back-to-back frames with no idle gap.
        fe0 = fe_a;
        send_frame(0, 7'h41, 1'b0, 1'b0, 1'b1, 0);
        check("b2b_first", idev_a, 8'h41);
        send_frame(0, 7'h5A, 1'b0, 1'b0, 1'b1, 10);
        check("b2b_second", idev_a, 8'hDA);
        check("b2b_ferr", fe_a - fe0, 0);

        // Four-cycle glitch must be rejected as a false start.
        t0  = cyc;
        fe0 = fe_a;
        rxd_a = 1'b0;
        wait_cycles(4);
        rxd_a = 1'b1;
        wait_cycles(30);
        check("glitch_busy_rise", rise_a - t0, 3);
        check("glitch_busy_fall", fall_a - t0, 11);
        check("glitch_data", idev_a, 8'hDA);
        check("glitch_errs", (fe_a - fe0) + (pe_a - pe0), 0);

        for (int i = 0; i < 7; i++) begin
            fe0 = fe_a;
            send_frame(0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop, 20);
            check($sformatf("vec%0d_data", i), idev_a, vecs[i].exp_data);
            check($sformatf("vec%0d_ferr", i), fe_a - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_busy", i), busy_a, 0);
        end

        // Bad stop followed by a long break: one frame error only.
        fe0 = fe_a;
        send_frame(0, 7'h55, 1'b0, 1'b0, 1'b0, 0);
        wait_cycles(500);
        check("break_busy_high", busy_a, 1);
        check("break_ferr_once", fe_a - fe0, 1);
        check("break_data", idev_a, 8'h01);
        rxd_a = 1'b1;
        wait_cycles(10);
        check("break_busy_low", busy_a, 0);
        send_frame(0, 7'h30, 1'b0, 1'b0, 1'b1, 10);
        check("break_recover", idev_a, 8'hB0);

        // Reset in the middle of data bit 3.
        fe0 = fe_a;
        pe0 = pe_a;
        rxd_a = 1'b0;
        wait_cycles(N);
        rxd_a = 1'b1;
        wait_cycles(3 * N + N / 2);
        rst_a = 1'b0;
        wait_cycles(3);
        check("midrst_data", idev_a, 8'h00);
        check("midrst_busy", busy_a, 0);
        check("midrst_ferr", fe_a_o, 0);
        check("midrst_perr", pe_a_o, 0);
        rst_a = 1'b1;
        wait_cycles(5);
        check("midrst_no_pulse", (fe_a - fe0) + (pe_a - pe0), 0);
        send_frame(0, 7'h7F, 1'b0, 1'b0, 1'b1, 10);
        check("midrst_recover", idev_a, 8'hFF);

        // Even parity instance.
        fe0 = fe_b;
        pe0 = pe_b;
        be0 = both_b;
        send_frame(1, 7'h03, 1'b1, 1'b1, 1'b1, 20);
        check("par_bad_perr", pe_b - pe0, 1);
        check("par_bad_data", idev_b, 8'h00);
        send_frame(1, 7'h03, 1'b1, 1'b0, 1'b1, 20);
        check("par_good_data", idev_b, 8'h83);
        check("par_good_perr", pe_b - pe0, 1);
        send_frame(1, 7'h07, 1'b1, 1'b0, 1'b0, 20);
        check("par_both_ferr", fe_b - fe0, 1);
        check("par_both_perr", pe_b - pe0, 2);
        check("par_both_same_cycle", both_b - be0, 1);
        check("par_both_data", idev_b, 8'h83);
        send_frame(1, 7'h07, 1'b1, 1'b1, 1'b1, 20);
        check("par_odd_count_data", idev_b, 8'h07);
        check("par_busy_low", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idev_serial_rx.md
# idev_serial_rx

Serial receiver that sits directly upstream of the CPU's input device 0 port and drives its 8-bit `in_idev0` bus. It recovers asynchronous 7-bit frames from a single `rxd` line by mid-bit sampling and holds the last good character on `idev_data`. Bit 7 of `idev_data` is a toggle flag that flips on every accepted character, so CPU software detects a new byte by polling the port without any read strobe. Bad frames are dropped and reported on one-cycle error pulses.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit (N). Legal range 4..255.
- `PARITY_EN`, default 0: 1 = a parity bit follows the data bits.
- `PARITY_ODD`, default 0: when `PARITY_EN`=1, 0 selects even parity and 1 selects odd.
- `clk` in 1: system clock, rising edge.
- `rst_bar` in 1: reset, asynchronous, active-low.
- `rxd` in 1: serial line, idle high, asynchronous to `clk`.
- `idev_data` out 8: bits [6:0] are the last good character; bit [7] is the toggle flag. Connects to `in_idev0`.
- `busy` out 1: high while a frame is being received.
- `frame_err` out 1: one-cycle pulse when the stop bit is bad.
- `parity_err` out 1: one-cycle pulse when parity is wrong.

## Operation
- **Input synchroniser.** `rxd` passes through two flops; both reset to 1. All logic uses the second stage, called `rxs`.
- **Frame format.** 1 start bit (0), 7 data bits LSB first, an optional parity bit, then 1 stop bit (1).
- **States:** IDLE, START, DATA, PARITY, STOP, WAITHI.
- **IDLE.**
  - Arms when `rxs`=0 and the previous `rxs`=1 (falling edge).
  - Loads the bit counter with H = N/2 (integer division) and goes to START.
- **START.**
  - When the counter expires, samples `rxs`.
  - `rxs`=1 is a false start: return to IDLE with no pulse.
  - `rxs`=0: go to DATA and reload the counter with N.
- **DATA.** Samples one bit every N cycles into a shift register, LSB first. After the 7th sample, goes to PARITY if `PARITY_EN`=1, else STOP.
- **PARITY.** Samples one bit and computes the check. The error is recorded and reported at the stop sample.
- **STOP.** Samples one bit.
  - Stop=1 and parity OK: on the next edge, `idev_data[6:0]` takes the shift register and `idev_data[7]` inverts. Go to IDLE.
  - Stop=1 and parity bad: pulse `parity_err`, leave `idev_data` unchanged, go to IDLE.
  - Stop=0: pulse `frame_err`, leave `idev_data` unchanged, go to WAITHI. If parity was also bad, pulse `parity_err` in the same cycle.
- **WAITHI.** Stays until `rxs`=1, then goes to IDLE. A held-low line (break) therefore produces exactly one `frame_err`.
- **Re-arm.** The return to IDLE happens at mid-stop-bit. A start edge arriving right after the stop bit is caught, so back-to-back frames need no idle gap.
- **`busy`.** High in START, DATA, PARITY, STOP and WAITHI; low in IDLE.
- **Outputs.** All outputs are registered, with no combinational path from `rxd`.

## Timing
- **Reset values:**
  - `idev_data`=8'h00, `busy`=0, `frame_err`=0, `parity_err`=0.
  - State is IDLE; synchroniser flops and previous-`rxs` are 1.
- **Reset mid-frame.** Aborts immediately with no pulse. The next full frame after release is received normally.
- **Synchroniser latency.** `rxs` follows `rxd` 2 cycles later.
- **Sample points.** Let E be the first cycle with `rxs`=0.
  - Start bit at E+H.
  - Data bit k (k=0..6) at E+H+(k+1)·N.
  - Parity at E+H+8N.
  - Stop at E+H+8N, or E+H+9N with parity.
- **Result latency.**
  - `idev_data` changes and the error pulses assert in the cycle after the stop sample.
  - Without parity: E+H+8N+1.
- **`busy` timing.** Rises in cycle E+1 and falls together with the `idev_data` update, except when leaving WAITHI.
- **Counter width.** 8 bits; behaviour with N outside 4..255 is not defined.
- **Toggle flag.** Wraps naturally (1 → 0). Only accepted characters flip it; errors never do.

## Test plan
- **Single frame.** N=16, no parity, reset, send 0x41 → `idev_data`=8'hC1 at E+137, `busy` low again, no error pulses.
- **Back-to-back frames.** Send 0x41 then 0x5A with zero idle gap → `idev_data` reads 8'h41, then 8'hDA. Toggle goes 1, 0, 1; both frames are accepted.
- **Glitch rejection.** Hold `rxd` low for 4 cycles → `busy` pulses and returns low by E+9. `idev_data` is unchanged and no error pulses occur.
- **Bad stop and break.** Send a frame with stop=0, then hold `rxd` low for 500 cycles → exactly one `frame_err` pulse and `idev_data` unchanged. `busy` stays high until `rxd` rises, and the next good 0x30 yields toggle set with low bits 0x30.
- **Parity.** `PARITY_EN`=1, `PARITY_ODD`=0: send 0x03 with parity bit 1 → one `parity_err` pulse and no update. Resend 0x03 with parity bit 0 → accepted, with `idev_data[6:0]`=7'h03.
- **Reset mid-frame.** Assert `rst_bar` low during data bit 3 → all outputs 0 within the reset. After release, send 0x7F → `idev_data`=8'hFF.
